// File: rtl/fix_checksum_engine.sv
// fix_checksum_engine: per-channel FIX tag-10 checksum calculator and verifier.
// Ports:
//   clk, rst          : clock and synchronous active-high reset
//   data_i, valid_i   : message byte and its qualifier
//   ch_i, start_i     : channel of the byte; byte is the first of a message
//   done_o            : one-cycle result pulse for channel ch_o
//   checksum_o        : computed checksum (mod 256)
//   rx_checksum_o     : value decoded from the "10=" field
//   match_o, err_o    : checksum agreed / message ended abnormally
//   err_code_o        : 0 none, 1 bad checksum field, 2 restarted, 3 too long
module fix_checksum_engine #(
  parameter int NUM_CH = 4,
  parameter int MAX_LEN = 4096,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      data_i,
  input  logic            valid_i,
  input  logic [CH_W-1:0] ch_i,
  input  logic            start_i,
  output logic            done_o,
  output logic [CH_W-1:0] ch_o,
  output logic [7:0]      checksum_o,
  output logic [7:0]      rx_checksum_o,
  output logic            match_o,
  output logic            err_o,
  output logic [1:0]      err_code_o
);
  localparam logic [7:0] SOH = 8'h01;
  localparam logic [7:0] ONE = 8'h31;
  localparam logic [7:0] ZERO = 8'h30;
  localparam logic [7:0] EQ = 8'h3D;
  localparam logic [7:0] TAG_ADJ = 8'h61;
  localparam logic [CH_W:0] NCH = (CH_W + 1)'(NUM_CH);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, BODY, TAG1, TAG0, DIGITS} state_t;

  state_t           st   [NUM_CH];
  logic [7:0]       sum  [NUM_CH];
  logic [LEN_W-1:0] cnt  [NUM_CH];
  logic [7:0]       val  [NUM_CH];
  logic [1:0]       dc   [NUM_CH];
  logic             big  [NUM_CH];
  logic             psoh [NUM_CH];

  logic             acc, rep, digit, nbig;
  logic [CH_W-1:0]  c;
  state_t           cs, ns;
  logic [7:0]       nsum, nval;
  logic [LEN_W-1:0] ncnt;
  logic [1:0]       ndc, code;
  logic [9:0]       prod;

  assign acc = valid_i && ({1'b0, ch_i} < NCH);
  // Out-of-range channels are never accepted; park the lookup on channel 0.
  assign c = acc ? ch_i : '0;
  assign cs = st[c];
  assign digit = (data_i >= 8'h30) && (data_i <= 8'h39);
  // At most two digits precede this one, so the value is <= 99 and 10 bits suffice.
  assign prod = 10'(val[c]) * 10'd10 + 10'(data_i - ZERO);

  always_comb begin
    ns = cs;
    nsum = sum[c];
    ncnt = cnt[c];
    nval = val[c];
    ndc = dc[c];
    nbig = big[c];
    rep = 1'b0;
    code = 2'd0;
    if (start_i) begin
      rep = cs != IDLE;
      code = (cs != IDLE) ? 2'd2 : 2'd0;
      ns = BODY;
      nsum = data_i;
      ncnt = LEN_W'(1);
      nval = '0;
      ndc = '0;
      nbig = 1'b0;
    end else if (cs != IDLE) begin
      if (cnt[c] == MAX_L) begin
        rep = 1'b1;
        code = 2'd3;
        ns = IDLE;
      end else begin
        ncnt = cnt[c] + LEN_W'(1);
        case (cs)
          BODY: begin
            nsum = sum[c] + data_i;
            ns = (psoh[c] && data_i == ONE) ? TAG1 : BODY;
          end
          TAG1: begin
            nsum = sum[c] + data_i;
            ns = (data_i == ZERO) ? TAG0 : BODY;
          end
          TAG0: begin
            // "1" and "0" were summed speculatively; take them back out on '='.
            nsum = (data_i == EQ) ? sum[c] - TAG_ADJ : sum[c] + data_i;
            ns = (data_i == EQ) ? DIGITS : BODY;
            nval = '0;
            ndc = '0;
            nbig = 1'b0;
          end
          DIGITS: begin
            if (digit && dc[c] != 2'd3) begin
              nval = prod[7:0];
              ndc = dc[c] + 2'd1;
              nbig = big[c] | (prod > 10'd255);
            end else begin
              rep = 1'b1;
              code = (data_i == SOH && dc[c] == 2'd3 && !big[c]) ? 2'd0 : 2'd1;
              ns = IDLE;
            end
          end
          default: ns = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst) begin
        st[k] <= IDLE;
        sum[k] <= '0;
        cnt[k] <= '0;
        val[k] <= '0;
        dc[k] <= '0;
        big[k] <= 1'b0;
        psoh[k] <= 1'b0;
      end else if (acc && c == CH_W'(k)) begin
        st[k] <= ns;
        sum[k] <= nsum;
        cnt[k] <= ncnt;
        val[k] <= nval;
        dc[k] <= ndc;
        big[k] <= nbig;
        psoh[k] <= data_i == SOH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_o <= 1'b0;
      ch_o <= '0;
      checksum_o <= '0;
      rx_checksum_o <= '0;
      match_o <= 1'b0;
      err_o <= 1'b0;
      err_code_o <= '0;
    end else begin
      done_o <= acc && rep;
      if (acc && rep) begin
        ch_o <= c;
        checksum_o <= sum[c];
        rx_checksum_o <= (code == 2'd0) ? val[c] : 8'd0;
        match_o <= code == 2'd0 && sum[c] == val[c];
        err_o <= code != 2'd0;
        err_code_o <= code;
      end
    end
  end
endmodule

// File: tb/tb_fix_checksum_engine.sv
// tb_fix_checksum_engine: directed and randomized checks of fix_checksum_engine against a message-level model.
module tb_fix_checksum_engine;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_i = '0;
  logic       valid_i = 1'b0;
  logic [1:0] ch_i = '0;
  logic       start_i = 1'b0;
  logic       done_o, match_o, err_o;
  logic [1:0] ch_o, err_code_o;
  logic [7:0] checksum_o, rx_checksum_o;
  logic       d2_done, d2_match, d2_err;
  logic [1:0] d2_ch, d2_code;
  logic [7:0] d2_sum, d2_rx;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0] msg [4][48];
  int         len [4];
  int         pos [4];
  logic [7:0] exp_s [4];
  logic [7:0] exp_r [4];

  fix_checksum_engine dut (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ch_i(ch_i), .start_i(start_i),
    .done_o(done_o), .ch_o(ch_o), .checksum_o(checksum_o), .rx_checksum_o(rx_checksum_o),
    .match_o(match_o), .err_o(err_o), .err_code_o(err_code_o)
  );

  fix_checksum_engine #(.NUM_CH(3), .MAX_LEN(8)) dut2 (
    .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .ch_i(ch_i), .start_i(start_i),
    .done_o(d2_done), .ch_o(d2_ch), .checksum_o(d2_sum), .rx_checksum_o(d2_rx),
    .match_o(d2_match), .err_o(d2_err), .err_code_o(d2_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input logic [1:0] ch, input logic [7:0] b, input bit s);
    valid_i = 1'b1;
    ch_i = ch;
    data_i = b;
    start_i = s;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic step(input logic [1:0] ch, input logic [7:0] b, input bit s, input bit rep,
                      input logic [7:0] es, input logic [7:0] er, input bit em, input bit ee,
                      input logic [1:0] ec);
    send(ch, b, s);
    if (rep) begin
      check("done", done_o, 1);
      check("ch", ch_o, ch);
      check("checksum", checksum_o, es);
      check("rx_checksum", rx_checksum_o, er);
      check("match", match_o, em);
      check("err", err_o, ee);
      check("err_code", err_code_o, ec);
    end else check("no_done", done_o, 0);
  endtask

  task automatic run(input logic [1:0] ch, input string s, input bit st0, input bit rep,
                     input logic [7:0] es, input logic [7:0] er, input bit em, input bit ee,
                     input logic [1:0] ec);
    for (int i = 0; i < s.len(); i++) begin
      logic [7:0] b;
      b = (s[i] == "|") ? 8'h01 : s[i];
      step(ch, b, st0 && i == 0, rep && i == s.len() - 1, es, er, em, ee, ec);
    end
  endtask

  // Random message: "8=" + body (no '=') + SOH, then "10=" + three digits + SOH.
  // Expected checksum is simply the byte sum of everything before "10=".
  task automatic build(input int ch);
    int n, s, v;
    logic [7:0] b;
    n = 0;
    msg[ch][n++] = 8'h38;
    msg[ch][n++] = 8'h3D;
    for (int i = $urandom_range(1, 20); i > 0; i--) begin
      b = ($urandom_range(0, 6) == 0) ? 8'h01 : 8'($urandom_range(32, 126));
      msg[ch][n++] = (b == 8'h3D) ? 8'h78 : b;
    end
    msg[ch][n++] = 8'h01;
    s = 0;
    for (int i = 0; i < n; i++) s += msg[ch][i];
    s = s % 256;
    v = ($urandom_range(0, 3) == 0) ? (s + $urandom_range(1, 255)) % 256 : s;
    msg[ch][n++] = 8'h31;
    msg[ch][n++] = 8'h30;
    msg[ch][n++] = 8'h3D;
    msg[ch][n++] = 8'(8'h30 + v / 100);
    msg[ch][n++] = 8'(8'h30 + (v / 10) % 10);
    msg[ch][n++] = 8'(8'h30 + v % 10);
    msg[ch][n++] = 8'h01;
    len[ch] = n;
    pos[ch] = 0;
    exp_s[ch] = 8'(s);
    exp_r[ch] = 8'(v);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_outputs", {done_o, ch_o, checksum_o, rx_checksum_o, match_o, err_o, err_code_o}, 0);
    check("reset_outputs2", {d2_done, d2_ch, d2_sum, d2_rx, d2_match, d2_err, d2_code}, 0);

    run(0, "8=A|10=183|", 1, 1, 183, 183, 1, 0, 0);
    valid_i = 1'b0;
    @(posedge clk);
    #1;
    check("hold_done", done_o, 0);
    check("hold_checksum", checksum_o, 183);
    check("hold_match", match_o, 1);

    run(0, "8=A|10=184|", 1, 1, 183, 184, 0, 0, 0);
    run(0, "8=A|10=1a", 1, 1, 183, 0, 0, 1, 1);
    run(0, "3|", 0, 0, 0, 0, 0, 0, 0);
    run(0, "8=A|10=256|", 1, 1, 183, 0, 0, 1, 1);
    run(0, "8=A|10=1834", 1, 1, 183, 0, 0, 1, 1);
    run(0, "8=A|10=18|", 1, 1, 183, 0, 0, 1, 1);

    for (int i = 0; i < 11; i++) begin
      string a, b;
      a = "8=A|10=183|";
      b = "8=B|10=184|";
      step(1, (a[i] == "|") ? 8'h01 : a[i], i == 0, i == 10, 183, 183, 1, 0, 0);
      step(3, (b[i] == "|") ? 8'h01 : b[i], i == 0, i == 10, 184, 184, 1, 0, 0);
    end

    run(0, "8=AB", 1, 0, 0, 0, 0, 0, 0);
    step(0, 8'h38, 1, 1, 248, 0, 0, 1, 2);
    run(0, "=A|10=183|", 0, 1, 183, 183, 1, 0, 0);

    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      string s;
      s = "8=ABCDEFG";
      send(0, s[i], i == 0);
      if (i < 8) check("len_no_done", d2_done, 0);
      else begin
        check("len_done", d2_done, 1);
        check("len_err_code", d2_code, 3);
        check("len_err", d2_err, 1);
        check("len_checksum", d2_sum, 10);
        check("len_match", d2_match, 0);
      end
    end
    for (int i = 0; i < 11; i++) begin
      string s;
      s = "8=A|10=183|";
      send(3, (s[i] == "|") ? 8'h01 : s[i], i == 0);
      check("bad_ch_ignored", d2_done, 0);
    end

    run(2, "8=A|1", 1, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      check("rst_no_done", done_o, 0);
    end
    rst = 1'b0;
    check("rst_outputs", {done_o, ch_o, checksum_o, rx_checksum_o, match_o, err_o, err_code_o}, 0);
    run(2, "0=A|10=183|", 0, 0, 0, 0, 0, 0, 0);
    run(2, "8=A|10=183|", 1, 1, 183, 183, 1, 0, 0);

    for (int k = 0; k < 4; k++) build(k);
    for (int it = 0; it < 3000; it++) begin
      int ch;
      ch = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) begin
        valid_i = 1'b0;
        ch_i = 2'(ch);
        data_i = 8'($urandom);
        start_i = 1'($urandom);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("idle_no_done", done_o, 0);
      end else begin
        bit last;
        last = pos[ch] == len[ch] - 1;
        step(2'(ch), msg[ch][pos[ch]], pos[ch] == 0, last, exp_s[ch], exp_r[ch],
             exp_s[ch] == exp_r[ch], 0, 0);
        pos[ch]++;
        if (last) build(ch);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/fix_checksum_engine.md
FIX_CHECKSUM_ENGINE -- requirements
Module: fix_checksum_engine

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent interleaved message channels (1..16).
REQ-002 Parameter MAX_LEN, default 4096, maximum bytes per message from start byte through terminating SOH, inclusive.
REQ-003 Derived localparams: CH_W = max(1, clog2(NUM_CH)); LEN_W = clog2(MAX_LEN+1).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 data_i  input  8  message byte.
REQ-007 valid_i  input  1  data_i, ch_i, start_i are qualified this cycle.
REQ-008 ch_i  input  CH_W  channel of the current byte.
REQ-009 start_i  input  1  current byte is the first byte of a message (the '8' of "8=").
REQ-010 done_o  output  1  one-cycle pulse: result or error for ch_o is valid.
REQ-011 ch_o  output  CH_W  channel of the reported result.
REQ-012 checksum_o  output  8  computed checksum, mod 256.
REQ-013 rx_checksum_o  output  8  checksum decoded from the "10=" field.
REQ-014 match_o  output  1  checksum_o == rx_checksum_o and err_o == 0.
REQ-015 err_o  output  1  message terminated abnormally.
REQ-016 err_code_o  output  2  0 none, 1 bad checksum field, 2 aborted by restart, 3 length overflow.

Function
REQ-017 Each channel SHALL hold private state: FSM, 8-bit sum, LEN_W-bit byte counter, 8-bit digit value, 2-bit digit count; bytes update only the state of channel ch_i.
REQ-018 Bytes with valid_i=0 SHALL be ignored; bytes with valid_i=1 and ch_i >= NUM_CH SHALL be ignored.
REQ-019 Per-channel FSM states: IDLE, BODY, TAG1 (SOH then '1' seen), TAG0 (SOH,'1','0' seen), DIGITS.
REQ-020 IDLE: valid byte without start_i ignored; with start_i -> BODY, sum = data_i, count = 1.
REQ-021 BODY: sum += data_i mod 256; if previous byte of this channel was SOH (0x01) and data_i = '1' (0x31) -> TAG1, else stay.
REQ-022 TAG1: sum += data_i; data_i = '0' (0x30) -> TAG0; else -> BODY (SOH-followed-by-'1' re-detected per REQ-021).
REQ-023 TAG0: data_i = '=' (0x3D) -> sum -= 0x61 mod 256 (removes '1','0'), '=' not added, digits cleared, -> DIGITS; other byte -> sum += data_i, -> BODY.
REQ-024 DIGITS: '0'..'9' with digit count < 3 -> value = value*10 + digit (10-bit intermediate, flag if > 255); sum unchanged.
REQ-025 DIGITS: SOH with digit count = 3 and value <= 255 -> report success, -> IDLE.
REQ-026 DIGITS: non-digit non-SOH, fourth digit, SOH with < 3 digits, or value > 255 -> report err_code 1, -> IDLE.
REQ-027 Byte counter increments on every accepted byte of an active channel; a byte that would make count exceed MAX_LEN -> report err_code 3, -> IDLE.
REQ-028 start_i on a channel not in IDLE -> report err_code 2 for the old message, and the same byte starts a new message per REQ-020.
REQ-029 Report: done_o, ch_o, checksum_o, rx_checksum_o, match_o, err_o, err_code_o registered, asserted exactly 1 cycle after the terminating byte; on error, checksum_o = current sum and rx_checksum_o = 0.
REQ-030 Outputs other than done_o SHALL hold their last values between reports; at most one report per cycle (one byte per cycle).
REQ-031 Sum SHALL include every message byte through the SOH preceding "10=", and no byte of "10=", the digits, or the final SOH.

Reset
REQ-032 rst=1 SHALL force every channel to IDLE, clear sum, count, digits, and drive all outputs to 0 on the next edge.
REQ-033 rst asserted mid-message SHALL discard the message without any report; first byte after rst release is treated as IDLE input.

Verification
REQ-034 ch0 bytes "8=A",SOH,"10=183",SOH with start_i on '8' -> 1 cycle after final SOH: done_o=1, ch_o=0, checksum_o=183, rx_checksum_o=183, match_o=1, err_o=0.
REQ-035 Same message with "10=184" -> checksum_o=183, rx_checksum_o=184, match_o=0, err_o=0.
REQ-036 Field "10=1a3" -> done_o on byte after 'a', err_o=1, err_code_o=1, match_o=0; "10=256" -> err_code_o=1.
REQ-037 Two messages interleaved byte-by-byte on ch1 and ch3 ("8=A..." and "8=B...") -> two reports, ch1 checksum 183, ch3 checksum 184, both match_o=1.
REQ-038 start_i on ch0 mid-body -> report err_code_o=2, then new message completes correctly; MAX_LEN=8 with 9-byte body -> err_code_o=3.
REQ-039 rst pulse mid-message on ch2 -> no done_o, all outputs 0; following complete message on ch2 -> correct report.
